d_cache: RTL
============

// Module: d_cache
// PURPOSE
// Direct-mapped, write-back data cache answering the MEM stage's d_rd/d_wr requests.
// - Returns read data one cycle later, in the WB cycle.
// - Raises d_miss combinationally so the pipeline holds MEM while the cache fetches or evicts over a simple req/ack backing-memory bus.
// - One 32-bit word per line. Addresses are word-aligned; d_addr[1:0] is ignored.
// PARAMETERS
// IDX_W    4   index width; LINES = 2**IDX_W
// CNT_W    16  width of the saturating miss counter
// PORTS
// clk          in   1      clock, all state on posedge
// rst          in   1      asynchronous, active-high reset
// d_addr       in   32     byte address from MEM stage
// d_rd         in   1      load request (already gated by flush upstream)
// d_wr         in   1      store request (already gated by flush upstream)
// d_wr_data    in   32     store data
// d_rd_data    out  32     load data, registered, valid the cycle after a hit
// d_miss       out  1      combinational stall to the pipeline
// mem_req      out  1      backing-memory request, held until mem_ack
// mem_we       out  1      1 = writeback, 0 = fill; stable while mem_req is high
// mem_addr     out  32     word address {tag,idx,2'b00}; stable while mem_req is high
// mem_wr_data  out  32     eviction data; stable while mem_req is high
// mem_ack      in   1      one-cycle completion pulse
// mem_rd_data  in   32     fill data, valid with mem_ack
// miss_cnt     out  CNT_W  number of misses entered, saturates at all-ones
// BEHAVIOUR
// - Address split: idx = d_addr[IDX_W+1:2], tag = d_addr[31:IDX_W+2].
// - Per-line state: valid, dirty, tag, data.
// - hit = valid[idx] & (tag_arr[idx]==tag).
// - Reset (async, any state):
//   - valid and dirty bits cleared; FSM goes to IDLE.
//   - d_rd_data, mem_req, mem_we, mem_addr, mem_wr_data and miss_cnt are 0.
//   - The tag and data arrays are not reset.
// - If d_rd and d_wr are both high, the request is treated as a store.
// - d_miss = (d_rd|d_wr) & ~(state==IDLE & (hit | store_install)). d_miss is 0 whenever there is no request.
// - store_install = d_wr & ~hit & ~(valid[idx]&dirty[idx]): the line is invalid or clean.
// - FSM states: IDLE, WB, FILL.
// - IDLE:
//   - Read hit: at the edge, d_rd_data <= data[idx]; d_miss=0.
//   - Write hit: data[idx] <= d_wr_data; dirty[idx] <= 1.
//   - store_install: same cycle, no bus traffic. Sets valid=1, dirty=1, tag and data.
//   - Miss on a valid dirty line (load or store):
//     - mem_req<=1, mem_we<=1, mem_addr<={tag_arr[idx],idx,2'b00}, mem_wr_data<=data[idx].
//     - Go to WB; miss_cnt++.
//   - Load miss on a clean or invalid line: mem_req<=1, mem_we<=0, mem_addr<={tag,idx,2'b00}; go to FILL; miss_cnt++.
//   - No request: d_rd_data holds its value.
// - WB:
//   - Wait for mem_ack.
//   - On ack: clear dirty[idx].
//   - If the request was a load: mem_we<=0, mem_addr<={tag,idx,2'b00}, mem_req stays 1; go to FILL.
//   - If the request was a store: mem_req<=0; go to IDLE. The store then installs next cycle.
// - FILL:
//   - Wait for mem_ack.
//   - On ack: data<=mem_rd_data, tag<=tag, valid<=1, dirty<=0, mem_req<=0; go to IDLE.
//   - The replayed request hits the next cycle. Minimum load-miss latency is 1 + bus latency + 1 cycles.
// - Miss target latch: the miss target (idx, tag, op) is latched on leaving IDLE. WB and FILL use the latched values, not the live d_addr.
// - Request dropped mid-miss (flush): the bus transaction always completes and the line is still installed. The FSM returns to IDLE with no further side effects.
// - mem_ack arriving in IDLE is ignored.
// - miss_cnt does not wrap; it holds at 2**CNT_W-1.
// TESTING
// All cases use IDX_W=4. Addresses 0x40, 0x80 and 0xC0 all map to idx 0, with tags 1, 2 and 3.
// 1. Reset, then d_rd@0x40.
//    - d_miss=1; next cycle mem_req=1, mem_we=0, mem_addr=0x40.
//    - Ack after 3 cycles with 0xDEADBEEF: d_miss=0 the cycle after, then d_rd_data=0xDEADBEEF. miss_cnt=1.
// 2. d_wr@0x40 with 0x00001234 -> d_miss=0, no mem_req; then d_rd@0x40 -> d_rd_data=0x00001234.
// 3. d_rd@0x80 with line 0 dirty.
//    - Writeback: mem_we=1, mem_addr=0x40, mem_wr_data=0x1234.
//    - After ack: fill, mem_we=0, mem_addr=0x80. Load returns the fill data; miss_cnt=2.
// 4. d_wr@0xC0 with line 0 clean -> d_miss=0, no bus traffic; subsequent d_rd@0xC0 returns the stored value.
// 5. Load miss, then d_rd drops during FILL -> mem_req stays high until ack; line installed; a later d_rd hits with no mem_req.
// 6. rst pulsed while mem_req=1 in FILL -> mem_req=0 and miss_cnt=0 immediately; next d_rd@0x80 misses; a mem_ack pulsed while idle after reset is ignored.

Source files
------------

// File: rtl/d_cache_if.sv
// rtl/d_cache_if.sv - MEM-stage request port and req/ack backing-memory bus of d_cache
interface d_cache_if #(parameter int CNT_W = 16);
   logic [31:0]      d_addr;
   logic             d_rd;
   logic             d_wr;
   logic [31:0]      d_wr_data;
   logic [31:0]      d_rd_data;
   logic             d_miss;
   logic             mem_req;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [31:0]      mem_wr_data;
   logic             mem_ack;
   logic [31:0]      mem_rd_data;
   logic [CNT_W-1:0] miss_cnt;

   modport slave (
      input  d_addr, d_rd, d_wr, d_wr_data, mem_ack, mem_rd_data,
      output d_rd_data, d_miss, mem_req, mem_we, mem_addr, mem_wr_data, miss_cnt
   );

   modport master (
      output d_addr, d_rd, d_wr, d_wr_data, mem_ack, mem_rd_data,
      input  d_rd_data, d_miss, mem_req, mem_we, mem_addr, mem_wr_data, miss_cnt
   );
endinterface

// File: rtl/d_cache.sv
// rtl/d_cache.sv - direct-mapped write-back data cache, one word per line
module d_cache #(
   parameter int IDX_W = 4,
   parameter int CNT_W = 16
) (
   input logic      clk,
   input logic      rst,
   d_cache_if.slave bus
);
   localparam int LINES = 2**IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic [1:0] {IDLE, WB, FILL} state_e;

   state_e             state_q, state_d;
   logic [LINES-1:0]   valid_q, valid_d;
   logic [LINES-1:0]   dirty_q, dirty_d;
   logic [TAG_W-1:0]   tag_arr [LINES];
   logic [31:0]        data_arr [LINES];

   logic [IDX_W-1:0]   m_idx_q, m_idx_d;
   logic [TAG_W-1:0]   m_tag_q, m_tag_d;
   logic               m_store_q, m_store_d;
   logic [31:0]        rd_data_q, rd_data_d;
   logic               mem_req_q, mem_req_d;
   logic               mem_we_q, mem_we_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wr_data_q, mem_wr_data_d;
   logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

   logic               arr_we;
   logic [IDX_W-1:0]   arr_idx;
   logic [TAG_W-1:0]   arr_tag;
   logic [31:0]        arr_data;

   logic [IDX_W-1:0]   idx;
   logic [TAG_W-1:0]   tag;
   logic               req, hit, line_dirty, store_install;
   logic [1:0]         unused_addr_lsb;

   assign idx             = bus.d_addr[IDX_W+1:2];
   assign tag             = bus.d_addr[31:IDX_W+2];
   assign unused_addr_lsb = bus.d_addr[1:0];
   assign req             = bus.d_rd | bus.d_wr;
   assign hit             = valid_q[idx] & (tag_arr[idx] == tag);
   assign line_dirty      = valid_q[idx] & dirty_q[idx];
   // A store to an invalid or clean line overwrites it in place without any bus traffic.
   assign store_install   = bus.d_wr & ~hit & ~line_dirty;
   assign bus.d_miss      = req & ~((state_q == IDLE) & (hit | store_install));

   assign bus.d_rd_data   = rd_data_q;
   assign bus.mem_req     = mem_req_q;
   assign bus.mem_we      = mem_we_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wr_data = mem_wr_data_q;
   assign bus.miss_cnt    = miss_cnt_q;

   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      dirty_d       = dirty_q;
      m_idx_d       = m_idx_q;
      m_tag_d       = m_tag_q;
      m_store_d     = m_store_q;
      rd_data_d     = rd_data_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      miss_cnt_d    = miss_cnt_q;
      arr_we        = 1'b0;
      arr_idx       = idx;
      arr_tag       = tag;
      arr_data      = bus.d_wr_data;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (hit && !bus.d_wr) begin
                  rd_data_d = data_arr[idx];
               end else if (hit || store_install) begin
                  arr_we       = 1'b1;
                  valid_d[idx] = 1'b1;
                  dirty_d[idx] = 1'b1;
               end else begin
                  m_idx_d   = idx;
                  m_tag_d   = tag;
                  m_store_d = bus.d_wr;
                  mem_req_d = 1'b1;
                  if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                  if (line_dirty) begin
                     mem_we_d      = 1'b1;
                     mem_addr_d    = {tag_arr[idx], idx, 2'b00};
                     mem_wr_data_d = data_arr[idx];
                     state_d       = WB;
                  end else begin
                     mem_we_d   = 1'b0;
                     mem_addr_d = {tag, idx, 2'b00};
                     state_d    = FILL;
                  end
               end
            end
         end
         WB: begin
            if (bus.mem_ack) begin
               dirty_d[m_idx_q] = 1'b0;
               // A store replays into the now-clean line; a load still needs its fill.
               if (m_store_q) begin
                  mem_req_d = 1'b0;
                  state_d   = IDLE;
               end else begin
                  mem_we_d   = 1'b0;
                  mem_addr_d = {m_tag_q, m_idx_q, 2'b00};
                  state_d    = FILL;
               end
            end
         end
         FILL: begin
            if (bus.mem_ack) begin
               arr_we           = 1'b1;
               arr_idx          = m_idx_q;
               arr_tag          = m_tag_q;
               arr_data         = bus.mem_rd_data;
               valid_d[m_idx_q] = 1'b1;
               dirty_d[m_idx_q] = 1'b0;
               mem_req_d        = 1'b0;
               state_d          = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         valid_q       <= '0;
         dirty_q       <= '0;
         m_idx_q       <= '0;
         m_tag_q       <= '0;
         m_store_q     <= 1'b0;
         rd_data_q     <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         miss_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         valid_q       <= valid_d;
         dirty_q       <= dirty_d;
         m_idx_q       <= m_idx_d;
         m_tag_q       <= m_tag_d;
         m_store_q     <= m_store_d;
         rd_data_q     <= rd_data_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         miss_cnt_q    <= miss_cnt_d;
      end
   end

   // Tag and data storage carries no reset; valid_q guards every use.
   always_ff @(posedge clk) begin
      if (arr_we) begin
         tag_arr[arr_idx]  <= arr_tag;
         data_arr[arr_idx] <= arr_data;
      end
   end
endmodule
